// File: rtl/dac_stream_arbiter_if.sv
// Handshake bundle between the two per-channel sample sources and the arbiter,
// plus the merged channel-tagged stream toward the AD56x3 driver sink.
// master = source/sink side (sample producers + DAC driver), slave = arbiter side.
interface dac_stream_arbiter_if #(
    parameter int DATA_WIDTH = 14
);
    logic                  asiAValid;
    logic [DATA_WIDTH-1:0] asiAData;
    logic                  asiARdy;
    logic                  asiBValid;
    logic [DATA_WIDTH-1:0] asiBData;
    logic                  asiBRdy;
    logic                  asoValid;
    logic                  asoChannel;
    logic [DATA_WIDTH-1:0] asoData;
    logic                  asoRdy;

    modport master (
        output asiAValid, asiAData, asiBValid, asiBData, asoRdy,
        input  asiARdy, asiBRdy, asoValid, asoChannel, asoData
    );

    modport slave (
        input  asiAValid, asiAData, asiBValid, asiBData, asoRdy,
        output asiARdy, asiBRdy, asoValid, asoChannel, asoData
    );
endinterface

// File: rtl/dac_stream_arbiter.sv
// Purpose: merge channel A/B sample streams into one channel-tagged stream for the DAC driver.
// Latency: sample accepted on edge k into an empty FIFO appears on asoValid after edge k+1.
// Backpressure: per-channel FIFO absorbs asoRdy stalls; asiXRdy is registered and drops once full.
// Optional feature macro: DAC_ARB_PAIR_EN (strict A,B pair ordering instead of round-robin).
module dac_stream_arbiter #(
    parameter int DATA_WIDTH = 14,
    parameter int FIFO_DEPTH = 4
) (
    input logic           clk,
    input logic           reset,
    dac_stream_arbiter_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    // Index 0 = channel A, index 1 = channel B throughout.
    logic [1:0]            in_vld;
    logic [DATA_WIDTH-1:0] in_dat [2];
    logic [1:0]            in_rdy;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            non_empty;
    logic [DATA_WIDTH-1:0] head [2];

    logic                  aso_valid;
    logic                  aso_channel;
    logic [DATA_WIDTH-1:0] aso_data;
    logic                  out_free;
    logic                  load;
    logic                  grant;

    assign in_vld    = {bus.asiBValid, bus.asiAValid};
    assign in_dat[0] = bus.asiAData;
    assign in_dat[1] = bus.asiBData;

    assign bus.asiARdy    = in_rdy[0];
    assign bus.asiBRdy    = in_rdy[1];
    assign bus.asoValid   = aso_valid;
    assign bus.asoChannel = aso_channel;
    assign bus.asoData    = aso_data;

    // The output register may take a new word when empty or when its word leaves this edge.
    assign out_free = !aso_valid || bus.asoRdy;
    assign pop      = load ? (grant ? 2'b10 : 2'b01) : 2'b00;

    for (genvar ch = 0; ch < 2; ch++) begin : g_fifo
        logic [PW-1:0]         wr_ptr;
        logic [PW-1:0]         rd_ptr;
        logic [CW-1:0]         cnt;
        logic [CW-1:0]         cnt_next;
        logic                  rdy_q;
        logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

        // Ready is registered, so a write is only taken when it was high before the edge.
        assign push[ch]      = in_vld[ch] && rdy_q;
        assign cnt_next      = cnt + CW'(push[ch]) - CW'(pop[ch]);
        assign in_rdy[ch]    = rdy_q;
        assign non_empty[ch] = (cnt != '0);
        assign head[ch]      = mem[rd_ptr];

        // Pointers wrap naturally since the depth is a power of two.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                rdy_q  <= 1'b0;
            end else begin
                if (push[ch]) wr_ptr <= wr_ptr + PW'(1);
                if (pop[ch])  rd_ptr <= rd_ptr + PW'(1);
                cnt   <= cnt_next;
                rdy_q <= (cnt_next < DEPTH_C);
            end
        end

        // Sample storage needs no reset; occupancy is tracked by cnt alone.
        always_ff @(posedge clk) begin
            if (push[ch]) mem[wr_ptr] <= in_dat[ch];
        end
    end

`ifdef DAC_ARB_PAIR_EN
    typedef enum logic {PAIR_A, PAIR_B} pair_state_t;
    pair_state_t state;
    pair_state_t state_next;

    // Pair sequencer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= PAIR_A;
        else        state <= state_next;
    end

    // Start a pair only when both channels have a sample, then always finish it with B.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        grant      = 1'b0;
        if (out_free) begin
            case (state)
                PAIR_A: begin
                    if (non_empty[0] && non_empty[1]) begin
                        load       = 1'b1;
                        grant      = 1'b0;
                        state_next = PAIR_B;
                    end
                end
                PAIR_B: begin
                    if (non_empty[1]) begin
                        load       = 1'b1;
                        grant      = 1'b1;
                        state_next = PAIR_A;
                    end
                end
                default: state_next = PAIR_A;
            endcase
        end
    end
`else
    logic last_grant;

    // Round-robin pick: alternate when both have data, otherwise take whichever has data.
    always_comb begin
        load  = out_free && (non_empty[0] || non_empty[1]);
        grant = 1'b0;
        if (non_empty[0] && non_empty[1]) grant = !last_grant;
        else                              grant = non_empty[1];
    end

    // Remember the last channel loaded; starts at B so A wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    last_grant <= 1'b1;
        else if (load) last_grant <= grant;
    end
`endif

    // Output register: reload when free, otherwise hold bit-stable for the driver.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            aso_valid   <= 1'b0;
            aso_channel <= 1'b0;
            aso_data    <= '0;
        end else if (out_free) begin
            aso_valid <= load;
            if (load) begin
                aso_channel <= grant;
                aso_data    <= head[grant];
            end
        end
    end
endmodule

// File: tb/tb_dac_stream_arbiter.sv
// Directed bench for dac_stream_arbiter (DATA_WIDTH 14, FIFO_DEPTH 4).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_dac_stream_arbiter;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   accepted;
    logic acc_now;

    logic [15:0] exp_ch  [6];
    logic [15:0] exp_dat [6];

    dac_stream_arbiter_if #(.DATA_WIDTH(14)) bus ();

    dac_stream_arbiter #(
        .DATA_WIDTH(14),
        .FIFO_DEPTH(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        accepted      = 0;
        acc_now       = 1'b0;
        reset         = 1'b0;
        bus.asiAValid = 1'b0;
        bus.asiAData  = '0;
        bus.asiBValid = 1'b0;
        bus.asiBData  = '0;
        bus.asoRdy    = 1'b0;

        exp_ch  = '{16'd0, 16'd1, 16'd0, 16'd1, 16'd0, 16'd1};
        exp_dat = '{16'd1, 16'd10, 16'd2, 16'd11, 16'd3, 16'd12};

        // Reset held for 10 cycles
        repeat (3) step();
        check("rst_ardy_early", 16'(bus.asiARdy), 16'h0);
        repeat (7) step();
        check("rst_valid", 16'(bus.asoValid), 16'h0);
        check("rst_channel", 16'(bus.asoChannel), 16'h0);
        check("rst_data", 16'(bus.asoData), 16'h0);
        check("rst_ardy", 16'(bus.asiARdy), 16'h0);
        check("rst_brdy", 16'(bus.asiBRdy), 16'h0);
        reset = 1'b1;
        step();
        check("rel_ardy", 16'(bus.asiARdy), 16'h1);
        check("rel_brdy", 16'(bus.asiBRdy), 16'h1);
        check("rel_valid", 16'(bus.asoValid), 16'h0);

        // Fairness: preload A 1,2,3 and B 10,11,12 while stalled
        bus.asoRdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.asiAValid = 1'b1;
            bus.asiAData  = 14'(i + 1);
            bus.asiBValid = 1'b1;
            bus.asiBData  = 14'(i + 10);
            step();
        end
        bus.asiAValid = 1'b0;
        bus.asiBValid = 1'b0;
        check("fair_hold_valid", 16'(bus.asoValid), 16'h1);
        check("fair_hold_data0", 16'(bus.asoData), 16'd1);
        step();
        check("fair_hold_data1", 16'(bus.asoData), 16'd1);
        bus.asoRdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("fair_valid", 16'(bus.asoValid), 16'h1);
            check("fair_channel", 16'(bus.asoChannel), exp_ch[i]);
            check("fair_data", 16'(bus.asoData), exp_dat[i]);
            step();
        end
        check("fair_drained", 16'(bus.asoValid), 16'h0);

`ifndef DAC_ARB_PAIR_EN
        // Single channel A word with the driver ready
        bus.asiAValid = 1'b1;
        bus.asiAData  = 14'h0123;
        step();
        bus.asiAValid = 1'b0;
        check("single_lat0", 16'(bus.asoValid), 16'h0);
        step();
        check("single_valid", 16'(bus.asoValid), 16'h1);
        check("single_channel", 16'(bus.asoChannel), 16'h0);
        check("single_data", 16'(bus.asoData), 16'h0123);
        step();
        check("single_gone", 16'(bus.asoValid), 16'h0);

        // Back-pressure: output holds an A word, then offer 6 words to B
        bus.asoRdy    = 1'b0;
        bus.asiAValid = 1'b1;
        bus.asiAData  = 14'h0AAA;
        step();
        bus.asiAValid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.asiBValid = 1'b1;
            bus.asiBData  = 14'(16'h0100 + accepted);
            acc_now       = bus.asiBRdy;
            step();
            if (acc_now) accepted++;
            check("bp_brdy", 16'(bus.asiBRdy), (i < 3) ? 16'h1 : 16'h0);
            check("bp_held_data", 16'(bus.asoData), 16'h0AAA);
        end
        bus.asiBValid = 1'b0;
        check("bp_accepted", 16'(accepted), 16'd4);
        check("bp_held_valid", 16'(bus.asoValid), 16'h1);
        check("bp_held_channel", 16'(bus.asoChannel), 16'h0);

        // Reset mid-stream with both FIFOs occupied
        bus.asiAValid = 1'b1;
        bus.asiAData  = 14'h0A01;
        step();
        bus.asiAData  = 14'h0A02;
        step();
        bus.asiAValid = 1'b0;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", 16'(bus.asoValid), 16'h0);
        check("mid_rst_data", 16'(bus.asoData), 16'h0);
        check("mid_rst_ardy", 16'(bus.asiARdy), 16'h0);
        check("mid_rst_brdy", 16'(bus.asiBRdy), 16'h0);
        repeat (2) step();
        reset = 1'b1;
        step();
        check("mid_rel_brdy", 16'(bus.asiBRdy), 16'h1);
        bus.asoRdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_no_stale", 16'(bus.asoValid), 16'h0);
        end
        bus.asiBValid = 1'b1;
        bus.asiBData  = 14'h0777;
        step();
        bus.asiBValid = 1'b0;
        step();
        check("mid_first_valid", 16'(bus.asoValid), 16'h1);
        check("mid_first_channel", 16'(bus.asoChannel), 16'h1);
        check("mid_first_data", 16'(bus.asoData), 16'h0777);
        step();
        check("mid_after", 16'(bus.asoValid), 16'h0);
`else
        // Pair mode: A alone never emits
        bus.asoRdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.asiAValid = 1'b1;
            bus.asiAData  = 14'(16'h00A0 + i);
            step();
            check("pair_a_only", 16'(bus.asoValid), 16'h0);
        end
        bus.asiAValid = 1'b0;
        repeat (2) step();
        check("pair_a_idle", 16'(bus.asoValid), 16'h0);
        bus.asiBValid = 1'b1;
        bus.asiBData  = 14'h00B0;
        step();
        bus.asiBValid = 1'b0;
        check("pair_b_lat0", 16'(bus.asoValid), 16'h0);
        step();
        check("pair_a0_valid", 16'(bus.asoValid), 16'h1);
        check("pair_a0_channel", 16'(bus.asoChannel), 16'h0);
        check("pair_a0_data", 16'(bus.asoData), 16'h00A0);
        step();
        check("pair_b0_channel", 16'(bus.asoChannel), 16'h1);
        check("pair_b0_data", 16'(bus.asoData), 16'h00B0);
        step();
        check("pair_stop0", 16'(bus.asoValid), 16'h0);
        step();
        check("pair_stop1", 16'(bus.asoValid), 16'h0);
        bus.asiBValid = 1'b1;
        bus.asiBData  = 14'h00B1;
        step();
        bus.asiBValid = 1'b0;
        step();
        check("pair_a1_channel", 16'(bus.asoChannel), 16'h0);
        check("pair_a1_data", 16'(bus.asoData), 16'h00A1);
        step();
        check("pair_b1_channel", 16'(bus.asoChannel), 16'h1);
        check("pair_b1_data", 16'(bus.asoData), 16'h00B1);
        step();
        check("pair_end", 16'(bus.asoValid), 16'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
